cla_pipe_addsub: RTL and testbench

- Parametrised successor to the team's 4-bit gate-level carry-lookahead adder.
- WIDTH-bit add/subtract built from 4-bit lookahead groups plus a second-level group-carry lookahead.
- Two-stage pipeline with valid/ready handshakes on both sides.
- Arithmetic datapath element for the course ALU and accumulator blocks.

---
 rtl/arith_pkg.sv | 23 ++
 rtl/cla4_grp.sv | 28 ++
 rtl/cla_pipe_addsub.sv | 182 ++++++++++++++++++
 tb/tb_cla_pipe_addsub.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arith_pkg.sv
// Shared definitions for the lookahead adder family: group width,
// propagate/generate pair type, op-codes and the 4-bit group P/G function.
package arith_pkg;

    localparam int GRP_W = 4;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef struct packed {
        logic p;
        logic g;
    } grp_pg_t;

    // Group propagate/generate of one 4-bit lookahead group.
    function automatic grp_pg_t grp_pg(input logic [GRP_W-1:0] p, input logic [GRP_W-1:0] g);
        grp_pg_t r;
        r.p = &p;
        r.g = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
        return r;
    endfunction

endpackage

// File: rtl/cla4_grp.sv
// One 4-bit carry-lookahead group: in-group carries, sums and group P/G.
module cla4_grp
    import arith_pkg::*;
(
    input  logic [GRP_W-1:0] p,
    input  logic [GRP_W-1:0] g,
    input  logic             cin,
    output logic [GRP_W-1:0] sum,
    output logic             grp_p,
    output logic             grp_g,
    output logic             c3
);

    logic [GRP_W-1:0] c;
    grp_pg_t          pg;

    assign c[0] = cin;
    assign c[1] = g[0] | (p[0] & cin);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);

    assign sum   = p ^ c;
    assign c3    = c[3];
    assign pg    = grp_pg(p, g);
    assign grp_p = pg.p;
    assign grp_g = pg.g;

endmodule

// File: rtl/cla_pipe_addsub.sv
// Two-stage pipelined WIDTH-bit add/subtract with two-level carry lookahead
// and valid/ready handshakes on both sides.
module cla_pipe_addsub
    import arith_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             co,
    output logic             ovf,
    output logic             zero
);

    localparam int NGRP = WIDTH / GRP_W;

    // Stage 1 state: per-bit and per-group propagate/generate.
    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0] p_q, p_d, g_q, g_d;
    logic [NGRP-1:0]  gp_q, gp_d, gg_q, gg_d;
    logic             cin_q, cin_d, sub_q, sub_d;

    // Stage 2 state: registered results.
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic             co_q, co_d, ovf_q, ovf_d, zero_q, zero_d;

    logic             s1_en, s2_en, accept;
    logic [WIDTH-1:0] b_int;
    grp_pg_t          pg;

    logic [NGRP:0]    c;
    logic             acc, term;
    logic [WIDTH-1:0] sum_w;
    logic [NGRP-1:0]  c3_all, grp_p_w, grp_g_w;
    logic             cout_int;
    logic             unused_grp_bits;

    // A stage may load when its downstream slot is free or draining this cycle.
    assign s2_en    = !out_valid_q | out_ready;
    assign s1_en    = !s1_valid_q | s2_en;
    assign in_ready = s1_en;
    assign accept   = in_valid & s1_en;

    assign b_int = (sub == OP_SUB) ? ~b : b;

    // Stage 1 next state: capture p/g, group P/G, internal carry-in and op on accept.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (which would infer a latch).
        s1_valid_d = s1_valid_q;
        p_d        = p_q;
        g_d        = g_q;
        gp_d       = gp_q;
        gg_d       = gg_q;
        cin_d      = cin_q;
        sub_d      = sub_q;
        pg         = '0;
        if (s1_en) begin
            s1_valid_d = in_valid;
        end
        if (accept) begin
            p_d   = a ^ b_int;
            g_d   = a & b_int;
            cin_d = (sub == OP_SUB) ? ~ci : ci;
            sub_d = sub;
            for (int k = 0; k < NGRP; k++) begin
                pg      = grp_pg(p_d[k*GRP_W +: GRP_W], g_d[k*GRP_W +: GRP_W]);
                gp_d[k] = pg.p;
                gg_d[k] = pg.g;
            end
        end
    end

    // Stage 1 registers.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: datapath registers are reset too, because the outputs must read zero during and after reset.
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            p_q        <= '0;
            g_q        <= '0;
            gp_q       <= '0;
            gg_q       <= '0;
            cin_q      <= 1'b0;
            sub_q      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values, independent of statement order.
            s1_valid_q <= s1_valid_d;
            p_q        <= p_d;
            g_q        <= g_d;
            gp_q       <= gp_d;
            gg_q       <= gg_d;
            cin_q      <= cin_d;
            sub_q      <= sub_d;
        end
    end

    // Flat group-carry lookahead: each c[k+1] is a sum of products of GG/GP and c[0].
    always_comb begin
        c    = '0;
        acc  = 1'b0;
        term = 1'b0;
        c[0] = cin_q;
        for (int k = 0; k < NGRP; k++) begin
            acc = cin_q;
            for (int m = 0; m <= k; m++) acc = acc & gp_q[m];
            for (int j = 0; j <= k; j++) begin
                term = gg_q[j];
                for (int m = j + 1; m <= k; m++) term = term & gp_q[m];
                acc = acc | term;
            end
            c[k+1] = acc;
        end
    end

    for (genvar k = 0; k < NGRP; k++) begin : g_grp
        cla4_grp u_grp (
            .p     (p_q[k*GRP_W +: GRP_W]),
            .g     (g_q[k*GRP_W +: GRP_W]),
            .cin   (c[k]),
            .sum   (sum_w[k*GRP_W +: GRP_W]),
            .grp_p (grp_p_w[k]),
            .grp_g (grp_g_w[k]),
            .c3    (c3_all[k])
        );
    end

    // Group P/G and lower carries are already covered by stage 1 and the lookahead.
    assign unused_grp_bits = ^{grp_p_w, grp_g_w, c3_all};

    assign cout_int = c[NGRP];

    // Stage 2 next state: load results when stage 1 holds data and the output slot frees.
    always_comb begin
        out_valid_d = out_valid_q;
        s_d         = s_q;
        co_d        = co_q;
        ovf_d       = ovf_q;
        zero_d      = zero_q;
        if (s2_en) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s_d    = sum_w;
                co_d   = (sub_q == OP_SUB) ? ~cout_int : cout_int;
                ovf_d  = c3_all[NGRP-1] ^ cout_int;
                zero_d = (sum_w == '0);
            end
        end
    end

    // Stage 2 / output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            s_q         <= '0;
            co_q        <= 1'b0;
            ovf_q       <= 1'b0;
            zero_q      <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            s_q         <= s_d;
            co_q        <= co_d;
            ovf_q       <= ovf_d;
            zero_q      <= zero_d;
        end
    end

    assign out_valid = out_valid_q;
    assign s         = s_q;
    assign co        = co_q;
    assign ovf       = ovf_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_cla_pipe_addsub.sv
// Directed and streaming checks of cla_pipe_addsub at WIDTH = 16, 4 and 32.
module tb_cla_pipe_addsub;

    typedef struct packed {
        logic        ovf;
        logic        zero;
        logic        co;
        logic [63:0] s;
    } res_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // WIDTH = 16 instance
    logic        in_valid, in_ready, ci, sub, out_valid, out_ready, co, ovf, zero;
    logic [15:0] a, b, s;
    // WIDTH = 4 instance
    logic        in_valid4, in_ready4, ci4, sub4, out_valid4, out_ready4, co4, ovf4, zero4;
    logic [3:0]  a4, b4, s4;
    // WIDTH = 32 instance
    logic        in_valid32, in_ready32, ci32, sub32, out_valid32, out_ready32, co32, ovf32, zero32;
    logic [31:0] a32, b32, s32;

    cla_pipe_addsub #(.WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .ci(ci), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
        .s(s), .co(co), .ovf(ovf), .zero(zero));

    cla_pipe_addsub #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
        .a(a4), .b(b4), .ci(ci4), .sub(sub4), .out_valid(out_valid4), .out_ready(out_ready4),
        .s(s4), .co(co4), .ovf(ovf4), .zero(zero4));

    cla_pipe_addsub #(.WIDTH(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid32), .in_ready(in_ready32),
        .a(a32), .b(b32), .ci(ci32), .sub(sub32), .out_valid(out_valid32), .out_ready(out_ready32),
        .s(s32), .co(co32), .ovf(ovf32), .zero(zero32));

    // Behavioural reference: plain + / - on w-bit operands, sign rule for overflow.
    function automatic res_t model(input int w, input logic [63:0] ma, input logic [63:0] mb,
                                   input logic mci, input logic msub);
        logic [64:0] full;
        logic [63:0] mask;
        logic        am, bm, sm;
        res_t        r;
        mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
        ma   = ma & mask;
        mb   = mb & mask;
        if (!msub) full = {1'b0, ma} + {1'b0, mb} + {64'd0, mci};
        else       full = {1'b0, ma} - {1'b0, mb} - {64'd0, mci};
        r.s    = full[63:0] & mask;
        r.co   = full[w];
        r.zero = (r.s == 64'd0);
        am = ma[w-1];
        bm = mb[w-1];
        sm = r.s[w-1];
        r.ovf  = msub ? ((am != bm) && (sm != am)) : ((am == bm) && (sm != am));
        return r;
    endfunction

    // Send one operation to the 16-bit DUT and collect its result (bounded waits).
    task automatic run16(input logic [15:0] ta, input logic [15:0] tb, input logic tci, input logic tsub,
                         output logic [18:0] res, output bit got);
        got = 1'b0;
        res = '0;
        @(negedge clk);
        a = ta; b = tb; ci = tci; sub = tsub; in_valid = 1'b1;
        #1;
        for (int i = 0; i < 10 && !in_ready; i++) begin
            @(negedge clk);
            #1;
        end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (out_valid) begin
                res = {s, co, ovf, zero};
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        total++;
        if ({out_valid, s, co, ovf, zero} !== 20'h0) begin
            bad++;
            $display("FAIL reset_outputs: got ov=%b s=%h co=%b ovf=%b z=%b, want all zero", out_valid, s, co, ovf, zero);
        end
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        rst_n = 1'b1;
        // 1 + 1 with latency check: result visible exactly two edges after accept
        @(negedge clk);
        a = 16'h0001; b = 16'h0001; ci = 1'b0; sub = 1'b0; in_valid = 1'b1;
        #1;
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL first_in_ready: got %b want 1", in_ready); end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL latency_early: out_valid=%b want 0 after one edge", out_valid); end
        @(negedge clk);
        #1;
        total++;
        if ({out_valid, s, co, ovf, zero} !== {1'b1, 16'h0002, 3'b000}) begin
            bad++;
            $display("FAIL first_result: got ov=%b s=%h co=%b ovf=%b z=%b, want ov=1 s=0002 co=0 ovf=0 z=0", out_valid, s, co, ovf, zero);
        end
        @(negedge clk);
        #1;
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL drain: out_valid=%b want 0", out_valid); end
    endtask

    task automatic test_directed(input string name, input logic [15:0] ta, input logic [15:0] tb,
                                 input logic tci, input logic tsub, input logic [18:0] want);
        logic [18:0] res;
        bit          got;
        run16(ta, tb, tci, tsub, res, got);
        total++;
        if (!got) begin
            bad++;
            $display("FAIL %s_timeout: no out_valid within budget", name);
        end else if (res !== want) begin
            bad++;
            $display("FAIL %s: got s=%h co=%b ovf=%b z=%b, want s=%h co=%b ovf=%b z=%b",
                     name, res[18:3], res[2], res[1], res[0], want[18:3], want[2], want[1], want[0]);
        end
    endtask

    task automatic test_backpressure;
        logic [15:0] exp_s [4];
        int tx = 0, rx = 0, stall_left = -1;
        exp_s = '{16'h0002, 16'h0004, 16'h0006, 16'h0008};
        for (int cyc = 0; cyc < 40 && rx < 4; cyc++) begin
            @(negedge clk);
            in_valid = (tx < 4);
            a = 16'(tx + 1); b = 16'(tx + 1); ci = 1'b0; sub = 1'b0;
            if (stall_left < 0 && out_valid) stall_left = 3;
            out_ready = !(stall_left > 0);
            #1;
            if (stall_left > 0) begin
                total++;
                if (out_valid !== 1'b1 || s !== 16'h0002) begin
                    bad++;
                    $display("FAIL stall_hold: got ov=%b s=%h, want ov=1 s=0002", out_valid, s);
                end
                total++;
                if (in_ready !== 1'b0) begin bad++; $display("FAIL stall_full: in_ready=%b want 0", in_ready); end
                stall_left--;
            end
            if (out_valid && out_ready) begin
                total++;
                if (s !== exp_s[rx]) begin
                    bad++;
                    $display("FAIL bp_result%0d: got s=%h want %h", rx, s, exp_s[rx]);
                end
                rx++;
            end
            if (in_valid && in_ready) tx++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        total++;
        if (rx != 4 || tx != 4) begin bad++; $display("FAIL bp_count: sent=%0d received=%0d want 4/4", tx, rx); end
        @(negedge clk);
        #1;
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_no_dup: out_valid=%b want 0", out_valid); end
    endtask

    task automatic test_async_reset;
        bit seen = 1'b0;
        @(negedge clk);
        a = 16'h0003; b = 16'h0004; ci = 1'b0; sub = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        a = 16'h0100; b = 16'h0200;
        @(negedge clk);
        in_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (out_valid) begin seen = 1'b1; break; end
            @(negedge clk);
        end
        total++;
        if (!seen || s !== 16'h0007) begin bad++; $display("FAIL ar_pre: seen=%b s=%h want 1/0007", seen, s); end
        #1;
        rst_n = 1'b0;
        #1;
        total++;
        if ({out_valid, s, co, ovf, zero} !== 20'h0) begin
            bad++;
            $display("FAIL ar_immediate: got ov=%b s=%h co=%b ovf=%b z=%b, want all zero", out_valid, s, co, ovf, zero);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL ar_discard: out_valid=%b want 0", out_valid); end
        test_directed("ar_after", 16'h0010, 16'h0020, 1'b0, 1'b0, {16'h0030, 3'b000});
    endtask

    task automatic test_sweep_w4;
        res_t q[$];
        res_t e;
        int   ntx = 0, nrx = 0;
        for (int cyc = 0; cyc < 1100 && nrx < 1002; cyc++) begin
            @(negedge clk);
            in_valid4 = (ntx < 1002);
            if (ntx == 0)      begin a4 = 4'hF; b4 = 4'h0; ci4 = 1'b1; sub4 = 1'b0; end
            else if (ntx == 1) begin a4 = 4'h5; b4 = 4'h7; ci4 = 1'b0; sub4 = 1'b1; end
            else begin
                a4 = 4'($urandom); b4 = 4'($urandom);
                ci4 = 1'($urandom_range(0, 1)); sub4 = 1'($urandom_range(0, 1));
            end
            #1;
            if (out_valid4) begin
                e = q.pop_front();
                total++;
                if (s4 !== e.s[3:0] || co4 !== e.co || ovf4 !== e.ovf || zero4 !== e.zero) begin
                    bad++;
                    $display("FAIL w4_vec%0d: got s=%h co=%b ovf=%b z=%b, want s=%h co=%b ovf=%b z=%b",
                             nrx, s4, co4, ovf4, zero4, e.s[3:0], e.co, e.ovf, e.zero);
                end
                nrx++;
            end
            if (in_valid4 && in_ready4) begin
                if (ntx == 0)      q.push_back('{ovf: 1'b0, zero: 1'b1, co: 1'b1, s: 64'h0});
                else if (ntx == 1) q.push_back('{ovf: 1'b0, zero: 1'b0, co: 1'b1, s: 64'hE});
                else               q.push_back(model(4, {60'd0, a4}, {60'd0, b4}, ci4, sub4));
                ntx++;
            end
        end
        in_valid4 = 1'b0;
        total++;
        if (nrx != 1002) begin bad++; $display("FAIL w4_count: received=%0d want 1002", nrx); end
    endtask

    task automatic test_sweep_w32;
        res_t q[$];
        res_t e;
        int   ntx = 0, nrx = 0;
        for (int cyc = 0; cyc < 1100 && nrx < 1002; cyc++) begin
            @(negedge clk);
            in_valid32 = (ntx < 1002);
            if (ntx == 0)      begin a32 = 32'hFFFF_FFFF; b32 = 32'h0; ci32 = 1'b1; sub32 = 1'b0; end
            else if (ntx == 1) begin a32 = 32'h5; b32 = 32'h7; ci32 = 1'b0; sub32 = 1'b1; end
            else begin
                a32 = $urandom; b32 = $urandom;
                ci32 = 1'($urandom_range(0, 1)); sub32 = 1'($urandom_range(0, 1));
            end
            #1;
            if (out_valid32) begin
                e = q.pop_front();
                total++;
                if (s32 !== e.s[31:0] || co32 !== e.co || ovf32 !== e.ovf || zero32 !== e.zero) begin
                    bad++;
                    $display("FAIL w32_vec%0d: got s=%h co=%b ovf=%b z=%b, want s=%h co=%b ovf=%b z=%b",
                             nrx, s32, co32, ovf32, zero32, e.s[31:0], e.co, e.ovf, e.zero);
                end
                nrx++;
            end
            if (in_valid32 && in_ready32) begin
                if (ntx == 0)      q.push_back('{ovf: 1'b0, zero: 1'b1, co: 1'b1, s: 64'h0});
                else if (ntx == 1) q.push_back('{ovf: 1'b0, zero: 1'b0, co: 1'b1, s: 64'hFFFF_FFFE});
                else               q.push_back(model(32, {32'd0, a32}, {32'd0, b32}, ci32, sub32));
                ntx++;
            end
        end
        in_valid32 = 1'b0;
        total++;
        if (nrx != 1002) begin bad++; $display("FAIL w32_count: received=%0d want 1002", nrx); end
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0;   a = '0;   b = '0;   ci = 1'b0;   sub = 1'b0;   out_ready = 1'b1;
        in_valid4 = 1'b0;  a4 = '0;  b4 = '0;  ci4 = 1'b0;  sub4 = 1'b0;  out_ready4 = 1'b1;
        in_valid32 = 1'b0; a32 = '0; b32 = '0; ci32 = 1'b0; sub32 = 1'b0; out_ready32 = 1'b1;

        test_reset();
        test_directed("carry_chain", 16'hFFFF, 16'h0000, 1'b1, 1'b0, {16'h0000, 3'b101});
        test_directed("signed_ovf",  16'h7FFF, 16'h0001, 1'b0, 1'b0, {16'h8000, 3'b010});
        test_directed("subtract",    16'h0005, 16'h0007, 1'b0, 1'b1, {16'hFFFE, 3'b100});
        test_directed("sub_borrow",  16'h8000, 16'h0001, 1'b1, 1'b1, {16'h7FFE, 3'b010});
        test_backpressure();
        test_async_reset();
        test_sweep_w4();
        test_sweep_w32();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
